stream_msg_buffer: RTL and testbench
====================================

Name: stream_msg_buffer

Overview:
- Two independent single-clock buffering functions for the image-processing datapath.
- Stream path: a full-throughput valid/ready pipeline register (2-entry skid buffer) carrying pixel/sop/eop words between the video sink and source.
- Message path: a show-ahead synchronous FIFO queuing 32-bit result words for CPU readout over the memory-mapped port.
- The two paths share only clock and reset.

Parameters:
- DATA_WIDTH, 26, stream word width ({R,G,B,sop,eop} in the video pipeline).
- MSG_WIDTH, 32, FIFO word width.
- MSG_DEPTH, 256, FIFO capacity in words (power of two).
- USEDW_WIDTH, 8, log2(MSG_DEPTH); width of the fill-level output.

Ports:
- clk, input, 1: single clock; all logic is rising-edge.
- reset_n, input, 1: asynchronous, active-low reset.
- valid_in, input, 1: upstream word valid.
- data_in, input, DATA_WIDTH: upstream word.
- ready_out, output, 1: register can accept (to upstream).
- valid_out, output, 1: downstream word valid.
- data_out, output, DATA_WIDTH: downstream word.
- ready_in, input, 1: downstream accepts.
- sclr, input, 1: synchronous FIFO clear.
- wrreq, input, 1: FIFO write request.
- data, input, MSG_WIDTH: FIFO write word.
- rdreq, input, 1: FIFO read acknowledge (pop head).
- q, output, MSG_WIDTH: FIFO head word (show-ahead).
- usedw, output, USEDW_WIDTH: words stored, modulo MSG_DEPTH.
- empty, output, 1: FIFO holds 0 words.
- full, output, 1: FIFO holds MSG_DEPTH words.

Behaviour:

Reset (reset_n low, asynchronous):
- valid_out=0, data_out=0, ready_out=1, skid register empty.
- FIFO count=0, empty=1, full=0, usedw=0, q=0.
- Effects are immediate. The first clocked action occurs on the first rising edge after deassertion.

Stream register:
- Transfer in when valid_in & ready_out. Transfer out when valid_out & ready_in.
- All outputs (valid_out, data_out, ready_out) are registered.
- Latency is 1 cycle from accepted input to valid_out.
- Sustains 1 word/cycle when ready_in stays high.
- ready_out = 1 iff the skid entry is empty.
- Input accepted while the output is stalled (valid_out & ~ready_in) goes to the skid entry; ready_out drops the next cycle.
- When the output is free (~valid_out or ready_in), the output register loads the skid word if present, else data_in when it is accepted.
- The skid entry drains first, so word order is preserved.
- data_out and valid_out hold stable while valid_out & ~ready_in.
- No word is dropped or duplicated.
- When a word leaves and no new word is available, valid_out goes low the next cycle. data_out may hold its last value.

Message FIFO (show-ahead):
- q shows the oldest word whenever empty=0. q is 0 after reset or sclr.
- Write is accepted iff wrreq & ~full. Read (pop) is accepted iff rdreq & ~empty. Acceptance uses pre-edge state.
- Write to a full FIFO is dropped. Read from an empty FIFO is ignored.
- Simultaneous accepted read and write: count unchanged, head advances, new word appended.
- Empty + wrreq + rdreq: write only; q shows the new word the next cycle.
- Full + wrreq + rdreq: pop only; the write is dropped.
- usedw = count mod MSG_DEPTH (reads 0 when full); full distinguishes full from empty.
- empty and full are registered, valid the cycle after the change.
- sclr empties the FIFO on the edge and has priority over wrreq/rdreq that cycle.
- Pointers wrap modulo MSG_DEPTH.
- Storage may be RAM or registers. q must reflect the new head the cycle after a pop or after a write into an empty FIFO.
- Reset mid-operation discards all contents and any in-flight stream word.

Test Plan:
- Stream streaming: ready_in=1; drive 5 words 0x1..0x5 on consecutive cycles → valid_out high cycles 1–5 with data_out 0x1..0x5; ready_out stays 1.
- Stream backpressure: ready_in=0 after word 0xA appears; offer 0xB and 0xC → 0xB skidded, ready_out=0, 0xC held upstream; release ready_in → output 0xA, 0xB, 0xC in order, no loss.
- FIFO fill/read: write 3 words "RBB"(0x00524242), 0x00050007, 0x00100020 → usedw=3, q=0x00524242; three rdreq pulses → q steps through the words, then empty=1, usedw=0.
- FIFO full: write 256 words i → full=1, usedw=0; a 257th write is dropped; read all → values 0..255 in order.
- Simultaneous events:
  - Empty + wr + rd → usedw=1.
  - Count 10 + wr + rd → usedw=10.
  - sclr with wrreq at count 5 → usedw=0, empty=1.
- Async reset: assert reset_n low mid-transfer with FIFO count 4 → immediately valid_out=0, ready_out=1, empty=1, usedw=0.

Source files
------------

// File: rtl/stream_msg_buffer.sv
// Stream skid register (valid/ready, full throughput) and an independent
// show-ahead message FIFO. The two paths share only clk and reset_n.
module stream_msg_buffer #(
  parameter int DATA_WIDTH  = 26,
  parameter int MSG_WIDTH   = 32,
  parameter int MSG_DEPTH   = 256,
  parameter int USEDW_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   valid_in,
  input  logic [DATA_WIDTH-1:0]  data_in,
  output logic                   ready_out,
  output logic                   valid_out,
  output logic [DATA_WIDTH-1:0]  data_out,
  input  logic                   ready_in,
  input  logic                   sclr,
  input  logic                   wrreq,
  input  logic [MSG_WIDTH-1:0]   data,
  input  logic                   rdreq,
  output logic [MSG_WIDTH-1:0]   q,
  output logic [USEDW_WIDTH-1:0] usedw,
  output logic                   empty,
  output logic                   full
);

  localparam int CNT_WIDTH = USEDW_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0]   DEPTH_C   = CNT_WIDTH'(MSG_DEPTH);
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE_C = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [USEDW_WIDTH-1:0] PTR_ONE_C = {{(USEDW_WIDTH-1){1'b0}}, 1'b1};

  logic                  valid_out_r;
  logic [DATA_WIDTH-1:0] data_out_r;
  logic                  skid_valid_r;
  logic [DATA_WIDTH-1:0] skid_data_r;
  logic                  out_free_s;
  logic                  accept_s;

  // Stream handshake qualifiers
  always_comb begin
    out_free_s = ~valid_out_r | ready_in;
    accept_s   = valid_in & ~skid_valid_r;
  end

  // Output/skid registers; a stalled output parks the accepted word in the skid slot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_out_r  <= 1'b0;
      data_out_r   <= {DATA_WIDTH{1'b0}};
      skid_valid_r <= 1'b0;
      skid_data_r  <= {DATA_WIDTH{1'b0}};
    end else if (out_free_s) begin
      if (skid_valid_r) begin
        valid_out_r  <= 1'b1;
        data_out_r   <= skid_data_r;
        skid_valid_r <= 1'b0;
      end else if (accept_s) begin
        valid_out_r <= 1'b1;
        data_out_r  <= data_in;
      end else begin
        valid_out_r <= 1'b0;
      end
    end else if (accept_s) begin
      skid_valid_r <= 1'b1;
      skid_data_r  <= data_in;
    end
  end

  assign valid_out = valid_out_r;
  assign data_out  = data_out_r;
  assign ready_out = ~skid_valid_r;

  logic [MSG_WIDTH-1:0]   mem_r [MSG_DEPTH];
  logic [USEDW_WIDTH-1:0] wr_ptr_r;
  logic [USEDW_WIDTH-1:0] rd_ptr_r;
  logic [CNT_WIDTH-1:0]   count_r;
  logic [MSG_WIDTH-1:0]   q_r;
  logic                   empty_r;
  logic                   full_r;
  logic                   do_wr_s;
  logic                   do_rd_s;
  logic [USEDW_WIDTH-1:0] rd_ptr_inc_s;
  logic [CNT_WIDTH-1:0]   count_next_s;
  logic [MSG_WIDTH-1:0]   q_next_s;

  // FIFO acceptance, next fill level and next head word
  always_comb begin
    do_wr_s      = wrreq & ~full_r;
    do_rd_s      = rdreq & ~empty_r;
    rd_ptr_inc_s = rd_ptr_r + PTR_ONE_C;
    case ({do_wr_s, do_rd_s})
      2'b10:   count_next_s = count_r + CNT_ONE_C;
      2'b01:   count_next_s = count_r - CNT_ONE_C;
      default: count_next_s = count_r;
    endcase
    // With one word left, a simultaneous write becomes the new head directly
    if (do_rd_s) begin
      if (count_r > CNT_ONE_C) begin
        q_next_s = mem_r[rd_ptr_inc_s];
      end else if (do_wr_s) begin
        q_next_s = data;
      end else begin
        q_next_s = q_r;
      end
    end else if (do_wr_s && empty_r) begin
      q_next_s = data;
    end else begin
      q_next_s = q_r;
    end
  end

  // FIFO control state; sclr wins over any request in the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {USEDW_WIDTH{1'b0}};
      rd_ptr_r <= {USEDW_WIDTH{1'b0}};
      count_r  <= {CNT_WIDTH{1'b0}};
      q_r      <= {MSG_WIDTH{1'b0}};
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else if (sclr) begin
      wr_ptr_r <= {USEDW_WIDTH{1'b0}};
      rd_ptr_r <= {USEDW_WIDTH{1'b0}};
      count_r  <= {CNT_WIDTH{1'b0}};
      q_r      <= {MSG_WIDTH{1'b0}};
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_inc_s;
      end
      count_r <= count_next_s;
      q_r     <= q_next_s;
      empty_r <= (count_next_s == {CNT_WIDTH{1'b0}});
      full_r  <= (count_next_s == DEPTH_C);
    end
  end

  // Storage array, written only on an accepted write
  always_ff @(posedge clk) begin
    if (do_wr_s && !sclr) begin
      mem_r[wr_ptr_r] <= data;
    end
  end

  assign q     = q_r;
  assign usedw = count_r[USEDW_WIDTH-1:0];
  assign empty = empty_r;
  assign full  = full_r;

endmodule

// File: tb/tb_stream_msg_buffer.sv
// Directed bench: table-driven stream vectors plus FIFO/reset sequences.
module tb_stream_msg_buffer;

  logic        clk;
  logic        reset_n;
  logic        valid_in;
  logic [25:0] data_in;
  logic        ready_out;
  logic        valid_out;
  logic [25:0] data_out;
  logic        ready_in;
  logic        sclr;
  logic        wrreq;
  logic [31:0] data;
  logic        rdreq;
  logic [31:0] q;
  logic [7:0]  usedw;
  logic        empty;
  logic        full;

  int checks;
  int failures;

  stream_msg_buffer dut (
    .clk(clk), .reset_n(reset_n),
    .valid_in(valid_in), .data_in(data_in), .ready_out(ready_out),
    .valid_out(valid_out), .data_out(data_out), .ready_in(ready_in),
    .sclr(sclr), .wrreq(wrreq), .data(data), .rdreq(rdreq),
    .q(q), .usedw(usedw), .empty(empty), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vin;
    logic [25:0] din;
    logic        rin;
    logic        evo;
    logic [25:0] edo;
    logic        ero;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge: apply inputs for one cycle, return at the next negedge
  task automatic fifo_op(input logic wr, input logic [31:0] d, input logic rd, input logic clr);
    wrreq = wr;
    data  = d;
    rdreq = rd;
    sclr  = clr;
    @(posedge clk);
    @(negedge clk);
    wrreq = 1'b0;
    rdreq = 1'b0;
    sclr  = 1'b0;
  endtask

  task automatic fifo_state(input string tag, input logic [7:0] eu, input logic ee, input logic ef);
    check({tag, ".usedw"}, {24'd0, usedw}, {24'd0, eu});
    check({tag, ".empty"}, {31'd0, empty}, {31'd0, ee});
    check({tag, ".full"},  {31'd0, full},  {31'd0, ef});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    valid_in = 1'b0;
    data_in  = 26'd0;
    ready_in = 1'b0;
    sclr     = 1'b0;
    wrreq    = 1'b0;
    data     = 32'd0;
    rdreq    = 1'b0;

    // streaming, ready_in held high
    vecs[0]  = '{1'b1, 26'h1, 1'b1, 1'b1, 26'h1, 1'b1};
    vecs[1]  = '{1'b1, 26'h2, 1'b1, 1'b1, 26'h2, 1'b1};
    vecs[2]  = '{1'b1, 26'h3, 1'b1, 1'b1, 26'h3, 1'b1};
    vecs[3]  = '{1'b1, 26'h4, 1'b1, 1'b1, 26'h4, 1'b1};
    vecs[4]  = '{1'b1, 26'h5, 1'b1, 1'b1, 26'h5, 1'b1};
    vecs[5]  = '{1'b0, 26'h0, 1'b1, 1'b0, 26'h0, 1'b1};
    // backpressure: A shown, B skidded, C held upstream, then drained in order
    vecs[6]  = '{1'b1, 26'hA, 1'b1, 1'b1, 26'hA, 1'b1};
    vecs[7]  = '{1'b1, 26'hB, 1'b0, 1'b1, 26'hA, 1'b0};
    vecs[8]  = '{1'b1, 26'hC, 1'b0, 1'b1, 26'hA, 1'b0};
    vecs[9]  = '{1'b1, 26'hC, 1'b1, 1'b1, 26'hB, 1'b1};
    vecs[10] = '{1'b1, 26'hC, 1'b1, 1'b1, 26'hC, 1'b1};
    vecs[11] = '{1'b0, 26'h0, 1'b1, 1'b0, 26'h0, 1'b1};
    // stall with nothing incoming holds the output word
    vecs[12] = '{1'b1, 26'hD, 1'b1, 1'b1, 26'hD, 1'b1};
    vecs[13] = '{1'b0, 26'h0, 1'b0, 1'b1, 26'hD, 1'b1};
    vecs[14] = '{1'b0, 26'h0, 1'b1, 1'b0, 26'h0, 1'b1};

    #12;
    check("rst.valid_out", {31'd0, valid_out}, 32'd0);
    check("rst.ready_out", {31'd0, ready_out}, 32'd1);
    check("rst.data_out",  {6'd0, data_out},   32'd0);
    check("rst.q",         q,                  32'd0);
    fifo_state("rst", 8'd0, 1'b1, 1'b0);

    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      valid_in = vecs[i].vin;
      data_in  = vecs[i].din;
      ready_in = vecs[i].rin;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d.valid_out", i), {31'd0, valid_out}, {31'd0, vecs[i].evo});
      check($sformatf("vec%0d.ready_out", i), {31'd0, ready_out}, {31'd0, vecs[i].ero});
      if (vecs[i].evo) begin
        check($sformatf("vec%0d.data_out", i), {6'd0, data_out}, {6'd0, vecs[i].edo});
      end
    end
    valid_in = 1'b0;

    // three words in, three pops
    fifo_op(1'b1, 32'h00524242, 1'b0, 1'b0);
    check("fill.q_first", q, 32'h00524242);
    fifo_op(1'b1, 32'h00050007, 1'b0, 1'b0);
    fifo_op(1'b1, 32'h00100020, 1'b0, 1'b0);
    fifo_state("fill3", 8'd3, 1'b0, 1'b0);
    check("fill3.q", q, 32'h00524242);
    fifo_op(1'b0, 32'd0, 1'b1, 1'b0);
    check("pop1.q", q, 32'h00050007);
    fifo_op(1'b0, 32'd0, 1'b1, 1'b0);
    check("pop2.q", q, 32'h00100020);
    fifo_op(1'b0, 32'd0, 1'b1, 1'b0);
    fifo_state("pop3", 8'd0, 1'b1, 1'b0);
    fifo_op(1'b0, 32'd0, 1'b1, 1'b0);
    fifo_state("pop_empty", 8'd0, 1'b1, 1'b0);

    // fill to capacity, overflow write dropped, drain in order
    for (int i = 0; i < 256; i++) fifo_op(1'b1, 32'(i), 1'b0, 1'b0);
    fifo_state("full", 8'd0, 1'b0, 1'b1);
    fifo_op(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    fifo_state("overflow", 8'd0, 1'b0, 1'b1);
    for (int i = 0; i < 256; i++) begin
      check($sformatf("drain%0d.q", i), q, 32'(i));
      fifo_op(1'b0, 32'd0, 1'b1, 1'b0);
    end
    fifo_state("drained", 8'd0, 1'b1, 1'b0);

    // full + wr + rd: pop only
    for (int i = 0; i < 256; i++) fifo_op(1'b1, 32'h1000 + 32'(i), 1'b0, 1'b0);
    fifo_op(1'b1, 32'h0000BEEF, 1'b1, 1'b0);
    fifo_state("full_wr_rd", 8'd255, 1'b0, 1'b0);
    check("full_wr_rd.q", q, 32'h00001001);
    fifo_op(1'b0, 32'd0, 1'b0, 1'b1);
    fifo_state("sclr", 8'd0, 1'b1, 1'b0);
    check("sclr.q", q, 32'd0);

    // empty + wr + rd: write only
    fifo_op(1'b1, 32'h00000077, 1'b1, 1'b0);
    fifo_state("empty_wr_rd", 8'd1, 1'b0, 1'b0);
    check("empty_wr_rd.q", q, 32'h00000077);
    fifo_op(1'b0, 32'd0, 1'b1, 1'b0);

    // count 10 + wr + rd keeps count, head advances
    for (int i = 0; i < 10; i++) fifo_op(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
    fifo_op(1'b1, 32'h00000999, 1'b1, 1'b0);
    fifo_state("cnt10_wr_rd", 8'd10, 1'b0, 1'b0);
    check("cnt10_wr_rd.q", q, 32'h00000101);
    for (int i = 0; i < 5; i++) fifo_op(1'b0, 32'd0, 1'b1, 1'b0);
    check("cnt5.usedw", {24'd0, usedw}, 32'd5);
    check("cnt5.q", q, 32'h00000106);
    fifo_op(1'b1, 32'h00000555, 1'b0, 1'b1);
    fifo_state("sclr_wr", 8'd0, 1'b1, 1'b0);
    check("sclr_wr.q", q, 32'd0);
    fifo_op(1'b1, 32'h000000AB, 1'b0, 1'b0);
    check("after_sclr.q", q, 32'h000000AB);
    fifo_state("after_sclr", 8'd1, 1'b0, 1'b0);
    fifo_op(1'b0, 32'd0, 1'b1, 1'b0);

    // async reset mid-transfer with 4 words queued and a skidded stream word
    for (int i = 0; i < 4; i++) fifo_op(1'b1, 32'h40 + 32'(i), 1'b0, 1'b0);
    valid_in = 1'b1;
    data_in  = 26'h3;
    ready_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    data_in = 26'h4;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst.valid_out", {31'd0, valid_out}, 32'd0);
    check("arst.ready_out", {31'd0, ready_out}, 32'd1);
    fifo_state("arst", 8'd0, 1'b1, 1'b0);
    check("arst.q", q, 32'd0);
    @(negedge clk);
    valid_in = 1'b0;
    ready_in = 1'b1;
    reset_n  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_rst.valid_out", {31'd0, valid_out}, 32'd0);
    fifo_state("post_rst", 8'd0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
